// File: rtl/cla_mp_seq.sv
// Multi-precision add/subtract sequencer: one N-bit carry-lookahead slice is
// reused across WORDS cycles, least-significant word first, with a registered inter-word carry.

module cla_slice #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);
    localparam int GROUPS = N / 4;

    logic [N-1:0]      g;
    logic [N-1:0]      p;
    logic [GROUPS-1:0] grp_g;
    logic [GROUPS-1:0] grp_p;
    logic [GROUPS:0]   c_grp;

    assign g = a & b;
    assign p = a ^ b;

    // Group carries resolved in one block so the chain never feeds back on itself.
    always_comb begin
        c_grp[0] = cin;
        for (int i = 0; i < GROUPS; i++) begin
            c_grp[i+1] = grp_g[i] | (grp_p[i] & c_grp[i]);
        end
    end

    assign cout = c_grp[GROUPS];

    for (genvar gi = 0; gi < GROUPS; gi++) begin : g_grp
        logic [3:0] gg;
        logic [3:0] pp;
        logic [3:0] cc;

        assign gg = g[gi*4 +: 4];
        assign pp = p[gi*4 +: 4];

        assign cc[0] = c_grp[gi];
        assign cc[1] = gg[0] | (pp[0] & cc[0]);
        assign cc[2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & cc[0]);
        assign cc[3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                     | (pp[2] & pp[1] & pp[0] & cc[0]);

        assign grp_g[gi] = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
                         | (pp[3] & pp[2] & pp[1] & gg[0]);
        assign grp_p[gi] = &pp;

        assign sum[gi*4 +: 4] = pp ^ cc;
    end
endmodule

module cla_mp_seq #(
    parameter int N     = 32,
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N*WORDS-1:0]   a,
    input  logic [N*WORDS-1:0]   b,
    input  logic                 cin,
    input  logic                 sub,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N*WORDS-1:0]   sum,
    output logic                 cout,
    output logic                 ovf,
    output logic                 busy
);
    localparam int W  = N * WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  sum_q, sum_d;
    logic          carry_q, carry_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          cout_q, cout_d;
    logic          ovf_q, ovf_d;

    logic [N-1:0]  a_words [WORDS];
    logic [N-1:0]  b_words [WORDS];
    logic [N-1:0]  cla_sum;
    logic          cla_cout;

    for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
        assign a_words[gi] = a_q[gi*N +: N];
        assign b_words[gi] = b_q[gi*N +: N];
        // Only the word currently being processed is overwritten.
        assign sum_d[gi*N +: N] = (state_q == RUN && idx_q == IW'(gi))
                                ? cla_sum : sum_q[gi*N +: N];
    end

    cla_slice #(.N(N)) u_cla (
        .a    (a_words[idx_q]),
        .b    (b_words[idx_q]),
        .cin  (carry_q),
        .sum  (cla_sum),
        .cout (cla_cout)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub | cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                carry_d = cla_cout;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    cout_d  = cla_cout;
                    // Carry into the MSB recovered as a ^ b ^ sum at that bit.
                    ovf_d   = a_q[W-1] ^ b_q[W-1] ^ cla_sum[N-1] ^ cla_cout;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
endmodule

// File: doc/cla_mp_seq.md
Name: cla_mp_seq

Overview:
- Multi-precision add/subtract sequencer built around one N-bit carry-lookahead adder (CLA_32bit for N=32).
- Adds or subtracts two N*WORDS-bit operands one N-bit word per cycle, least-significant word first.
- The inter-word carry is held in a register.
- Valid/ready handshakes on both input and output let it sit between an operand producer and a result consumer in the datapath.

Parameters:
- N, 32: width of the shared CLA slice, in bits.
- WORDS, 4: number of N-bit words per operand. Operand width W = N*WORDS. Minimum value is 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  operand request valid.
- in_ready  output  1  block can accept an operand request.
- a  input  W  operand A.
- b  input  W  operand B.
- cin  input  1  carry-in for add. Ignored when sub=1.
- sub  input  1  0 computes a+b+cin; 1 computes a-b.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  W  result.
- cout  output  1  carry-out of the MSB word. For sub this is the not-borrow flag (1 means a>=b unsigned).
- ovf  output  1  signed overflow: carry into the MSB of the result XOR carry out of the MSB.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state=IDLE, idx=0, carry register=0, sum=0, cout=0, ovf=0, out_valid=0, busy=0.
  - in_ready=1 while rst=0 and state=IDLE. in_ready=0 while rst=1.
- States: IDLE, RUN, DONE.
  - in_ready = (state==IDLE).
  - out_valid = (state==DONE).
- IDLE:
  - On in_valid&&in_ready at edge T, register a, b-or-~b and sub.
  - Set carry = sub ? 1 : cin, idx=0, and go to RUN.
  - After acceptance, input changes have no effect on the result.
- RUN:
  - Each cycle, the CLA adds word idx of A, word idx of the registered (possibly inverted) B, and the carry.
  - On the edge, the N-bit result goes into sum word idx, CLA cout goes into carry, and idx increments.
  - On the edge that processes idx=WORDS-1, the last word is written, cout and ovf are latched, and state goes to DONE.
  - ovf uses the MSB of the registered A, the registered B and the result.
- Latency:
  - Accept at edge T; out_valid first high after edge T+WORDS.
  - The request takes exactly WORDS RUN cycles.
- DONE:
  - sum, cout and ovf are held stable while out_valid=1 and out_ready=0.
  - On out_valid&&out_ready, go to IDLE; in_ready is high the next cycle.
  - The result registers keep their value after the handshake until the next run overwrites them.
  - There is no same-cycle accept of a new request in DONE; back-to-back throughput is one op per WORDS+2 cycles.
- in_valid while busy is ignored. The producer must hold the request until in_ready.
- out_ready while not in DONE is ignored.
- Reset mid-operation (RUN or DONE) aborts the operation and discards the partial result; no out_valid pulse is produced.
- Carry wrap: the carry out of word WORDS-1 does not feed back. It appears only on cout.
- Subtraction uses two's complement: ~b with forced carry-in 1. Results are modulo 2^W.
- The CLA Pout/Gout outputs are unused.

Test Plan:
- Add, sub=0, cin=0, WORDS=4: a=all ones, b=1 -> sum=0, cout=1, ovf=0; out_valid rises 4 edges after accept; in_ready=0 during RUN.
- Inter-word carry ripple: a=0x00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF, b=0, cin=1 -> sum=0x00000001_00000000_00000000_00000000, cout=0.
- Subtract: a=5, b=7, sub=1 -> sum=0xFFFF..FFFE (128-bit), cout=0, ovf=0. Then a=7, b=5 -> sum=2, cout=1.
- Signed overflow: a=0x7FFF..FFFF, b=1, sub=0 -> sum=0x8000..0000, ovf=1, cout=0. Also a=0x8000..0000, b=1, sub=1 -> ovf=1.
- Backpressure:
  - Hold out_ready=0 for 3 cycles in DONE -> sum, cout, ovf and out_valid stay stable; in_ready=0; in_valid with new operands is not taken.
  - Then out_ready=1 -> IDLE, and the new request is accepted the following cycle.
- Reset mid-operation:
  - Assert rst asynchronously (between clock edges) at idx=2 -> out_valid=0, busy=0 and sum=0 immediately.
  - After release, a=3, b=4 completes with sum=7 and no stale carry.
